// File: rtl/seg_scan_display.sv
// Four-digit multiplexed 7-segment driver for the up/down counter: hex value, direction letter
// and, when WRAP_CNT_EN is defined, an 8-bit wrap count on digits 3:2. Data changes only per frame.
module seg_scan_display #(
   parameter int SCAN_DIV = 50000
`ifdef WRAP_CNT_EN
   ,
   parameter int WRAP_W   = 8
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] val,
   input  logic       dir,
   input  logic       val_vld,
   input  logic       blank,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       frame
);

   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [6:0]       SEG_U    = 7'b0111110;
   localparam logic [6:0]       SEG_D    = 7'b0111101;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      case (nib)
         4'h0:    hex7 = 7'h7E;
         4'h1:    hex7 = 7'h30;
         4'h2:    hex7 = 7'h6D;
         4'h3:    hex7 = 7'h79;
         4'h4:    hex7 = 7'h33;
         4'h5:    hex7 = 7'h5B;
         4'h6:    hex7 = 7'h5F;
         4'h7:    hex7 = 7'h70;
         4'h8:    hex7 = 7'h7F;
         4'h9:    hex7 = 7'h7B;
         4'hA:    hex7 = 7'h77;
         4'hB:    hex7 = 7'h1F;
         4'hC:    hex7 = 7'h4E;
         4'hD:    hex7 = 7'h3D;
         4'hE:    hex7 = 7'h4F;
         4'hF:    hex7 = 7'h47;
         default: hex7 = 7'h00;
      endcase
   endfunction

   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   logic             frame_q, frame_d;
   logic [6:0]       seg_q, seg_d;
   logic [6:0]       seg_mux_s;
   logic [3:0]       sval_q, sval_d;
   logic             sdir_q, sdir_d;
   logic [3:0]       val_q, val_d;
   logic             dir_q, dir_d;
   logic             tc_s;
   logic             frame_evt_s;

`ifdef WRAP_CNT_EN
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   logic              wrap_hit_s;

   // Count roll-overs in either direction, judged against the last accepted value.
   always_comb begin
      wrap_hit_s = val_vld &&
                   (((sval_q == 4'hF) && (val == 4'h0) && dir) ||
                    ((sval_q == 4'h0) && (val == 4'hF) && !dir));
      wrap_d     = wrap_hit_s ? (wrap_q + WRAP_W'(1)) : wrap_q;
   end

   // Wrap counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap_q <= '0;
      end else begin
         wrap_q <= wrap_d;
      end
   end
`endif

   // Prescaler, digit scan, shadow capture, frame-aligned update and segment mux.
   always_comb begin
      tc_s        = (div_q == DIV_LAST);
      frame_evt_s = tc_s && (idx_q == 2'd3);
      div_d       = tc_s ? '0 : (div_q + DIV_W'(1));
      idx_d       = tc_s ? (idx_q + 2'd1) : idx_q;
      an_d        = 4'b0001 << idx_d;
      frame_d     = frame_evt_s;
      sval_d      = val_vld ? val : sval_q;
      sdir_d      = val_vld ? dir : sdir_q;
      // sval_d/sdir_d already carry a same-cycle strobe, which gives the bypass
      if (frame_evt_s) begin
         val_d = sval_d;
         dir_d = sdir_d;
      end else begin
         val_d = val_q;
         dir_d = dir_q;
      end
      case (idx_q)
         2'd0:    seg_mux_s = hex7(val_q);
         2'd1:    seg_mux_s = dir_q ? SEG_U : SEG_D;
`ifdef WRAP_CNT_EN
         2'd2:    seg_mux_s = hex7(wrap_q[3:0]);
         2'd3:    seg_mux_s = hex7(wrap_q[7:4]);
`endif
         default: seg_mux_s = 7'b0000000;
      endcase
      seg_d = blank ? 7'b0000000 : seg_mux_s;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q   <= '0;
         idx_q   <= 2'd0;
         an_q    <= 4'b0001;
         frame_q <= 1'b0;
         seg_q   <= 7'b0000000;
         sval_q  <= 4'h0;
         sdir_q  <= 1'b1;
         val_q   <= 4'h0;
         dir_q   <= 1'b1;
      end else begin
         div_q   <= div_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         frame_q <= frame_d;
         seg_q   <= seg_d;
         sval_q  <= sval_d;
         sdir_q  <= sdir_d;
         val_q   <= val_d;
         dir_q   <= dir_d;
      end
   end

   assign seg   = seg_q;
   assign an    = an_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=4 (4 cycles per digit, 16 per frame).
// Wrap-count expectations follow WRAP_CNT_EN.
module tb_seg_scan_display;

`ifdef WRAP_CNT_EN
   localparam bit WRAP_ON = 1'b1;
`else
   localparam bit WRAP_ON = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] val;
   logic       dir;
   logic       val_vld;
   logic       blank;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame;

   int         checks;
   int         errors;
   logic [6:0] dig [4];

   seg_scan_display #(.SCAN_DIV(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .val     (val),
      .dir     (dir),
      .val_vld (val_vld),
      .blank   (blank),
      .seg     (seg),
      .an      (an),
      .frame   (frame)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      check_val("rst_seg", {1'b0, seg}, 8'h00);
      check_val("rst_an", {4'h0, an}, 8'h01);
      check_val("rst_frame", {7'd0, frame}, 8'h00);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_frame();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (frame) begin
            found = 1'b1;
            break;
         end
      end
      check_val("frame_seen", {7'd0, found}, 8'h01);
   endtask

   // Returns 13 negedges after the frame pulse, in the second cycle of digit 3.
   task automatic sample_frame();
      wait_frame();
      for (int k = 0; k < 4; k++) begin
         repeat ((k == 0) ? 1 : 4) @(negedge clk);
         dig[k] = seg;
         check_val("scan_an", {4'h0, an}, 8'(4'b0001 << k));
      end
   endtask

   task automatic strobe(input logic [3:0] v, input logic d);
      val     = v;
      dir     = d;
      val_vld = 1'b1;
      @(negedge clk);
      val_vld = 1'b0;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      val     = 4'h0;
      dir     = 1'b1;
      val_vld = 1'b0;
      blank   = 1'b0;

      // 1. reset, then mid-frame reset, then the reset image
      do_reset();
      repeat (6) @(negedge clk);
      check_val("pre_rst_an", {4'h0, an}, 8'h02);
      check_val("pre_rst_seg", {1'b0, seg}, 8'h3E);
      do_reset();
      sample_frame();
      check_val("t1_d0", {1'b0, dig[0]}, 8'h7E);
      check_val("t1_d1", {1'b0, dig[1]}, 8'h3E);
      check_val("t1_d2", {1'b0, dig[2]}, WRAP_ON ? 8'h7E : 8'h00);
      check_val("t1_d3", {1'b0, dig[3]}, WRAP_ON ? 8'h7E : 8'h00);

      // 2. mid-frame strobe held back until the frame boundary
      wait_frame();
      @(negedge clk);
      check_val("t2_d0_old", {1'b0, seg}, 8'h7E);
      strobe(4'hA, 1'b0);
      repeat (3) @(negedge clk);
      check_val("t2_d1_old", {1'b0, seg}, 8'h3E);
      sample_frame();
      check_val("t2_d0", {1'b0, dig[0]}, 8'h77);
      check_val("t2_d1", {1'b0, dig[1]}, 8'h3D);

      // 3. last strobe wins
      strobe(4'h3, 1'b1);
      strobe(4'h5, 1'b1);
      sample_frame();
      check_val("t3_d0", {1'b0, dig[0]}, 8'h5B);
      check_val("t3_d1", {1'b0, dig[1]}, 8'h3E);
      check_val("t3_d2", {1'b0, dig[2]}, WRAP_ON ? 8'h7E : 8'h00);

      // 4. up-wrap then down-wrap; a repeated value is not a wrap
      strobe(4'hF, 1'b1);
      strobe(4'h0, 1'b1);
      sample_frame();
      check_val("t4_up_d0", {1'b0, dig[0]}, 8'h7E);
      check_val("t4_up_d2", {1'b0, dig[2]}, WRAP_ON ? 8'h30 : 8'h00);
      check_val("t4_up_d3", {1'b0, dig[3]}, WRAP_ON ? 8'h7E : 8'h00);
      strobe(4'h0, 1'b0);
      strobe(4'hF, 1'b0);
      sample_frame();
      check_val("t4_dn_d0", {1'b0, dig[0]}, 8'h47);
      check_val("t4_dn_d1", {1'b0, dig[1]}, 8'h3D);
      check_val("t4_dn_d2", {1'b0, dig[2]}, WRAP_ON ? 8'h6D : 8'h00);

      // strobe on the wrap cycle itself goes straight to the shown value
      repeat (2) @(negedge clk);
      strobe(4'h7, 1'b1);
      check_val("byp_frame", {7'd0, frame}, 8'h01);
      @(negedge clk);
      check_val("byp_d0", {1'b0, seg}, 8'h70);

      // 6. blank with scan timing
      wait_frame();
      blank = 1'b1;
      check_val("t6_an0", {4'h0, an}, 8'h01);
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         check_val("t6_an", {4'h0, an}, 8'(4'b0001 << (i / 4)));
         check_val("t6_seg", {1'b0, seg}, 8'h00);
         if (i == 1) check_val("t6_frame_1cyc", {7'd0, frame}, 8'h00);
      end
      @(negedge clk);
      check_val("t6_frame_16", {7'd0, frame}, 8'h01);
      check_val("t6_an_wrap", {4'h0, an}, 8'h01);
      blank = 1'b0;
      @(negedge clk);
      check_val("t6_unblank", {1'b0, seg}, 8'h70);

`ifdef WRAP_CNT_EN
      // 5. wrap counter roll-over
      do_reset();
      for (int n = 0; n < 255; n++) begin
         strobe(4'hF, 1'b1);
         strobe(4'h0, 1'b1);
      end
      sample_frame();
      check_val("t5_ff_d2", {1'b0, dig[2]}, 8'h47);
      check_val("t5_ff_d3", {1'b0, dig[3]}, 8'h47);
      strobe(4'hF, 1'b1);
      strobe(4'h0, 1'b1);
      sample_frame();
      check_val("t5_00_d2", {1'b0, dig[2]}, 8'h7E);
      check_val("t5_00_d3", {1'b0, dig[3]}, 8'h7E);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
